block_nest_checker: RTL
=======================

Name: block_nest_checker

Overview:
- Parametrised successor of the single-pair keyword block checker.
- Consumes one ASCII character per clock. Recognises space-delimited, case-insensitive open/close keywords of several kinds.
- Tracks proper nesting with a type stack and reports balance, current depth and a sticky structural error.
- Sits on the character-stream path next to the other text-scanning blocks.

Parameters:
- DEPTH, 16, maximum nesting depth (stack entries); must be ≥1.
- DEPTH_W, $clog2(DEPTH+1), derived localparam; width of the depth output; not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  8  ASCII character, sampled every rising clk edge.
- result  output  1  1 when the stream so far is balanced and error-free.
- depth  output  DEPTH_W  effective nesting depth.
- error  output  1  sticky structural error.

Behaviour:
- Folding: ch = in | 8'h20. Space (8'h20) is the only delimiter. Every other byte is a word character; non-letters never match a keyword.
- Keywords: "begin" opens type T_BEGIN; "end" closes T_BEGIN. "fork" opens T_FORK; "join" closes T_FORK.
- A keyword matches only if the whole word equals it. Example: "beginx", "xend" and "en" are plain words.
- Word FSM (kw_matcher):
  - States: IDLE, prefix states (B, BE, BEG, BEGI, BEGIN; E, EN, END; F, FO, FOR, FORK; J, JO, JOI, JOIN) and SKIP.
  - Space from any state → IDLE. Multiple spaces stay in IDLE.
  - A non-matching character from IDLE or a prefix state → SKIP. SKIP holds until a space.
  - A character after a full keyword → SKIP.
  - kw output is the keyword code when the state is a full-keyword state, else KW_NONE.
- Commit: on the edge that samples a space while kw != KW_NONE, the keyword is applied to the committed stack (sp, entries).
  - Open: push type. If sp == DEPTH, set err instead (overflow).
  - Close: if sp == 0 (underflow) or top type != keyword type (mismatch), set err. Otherwise pop.
  - Once err = 1, stack and err freeze until reset. The word FSM keeps running.
- Pending view: outputs include the current, not-yet-terminated keyword as if it were terminated, so a stream need not end with a space.
  - Pending open: eff_depth = sp+1; eff_err = err | (sp == DEPTH).
  - Pending close: eff_depth = sp−1; eff_err = err | underflow | mismatch.
  - Otherwise: eff_depth = sp; eff_err = err.
  - If eff_err, depth outputs the frozen sp.
- Outputs are combinational from registers only, never from `in`. They reflect every character sampled up to the last edge; latency is 1 cycle from the char being presented.
  - result = !eff_err && eff_depth == 0.
  - error = eff_err.
- Reset: async. Immediately sets FSM = IDLE, sp = 0, err = 0, stack cleared, so result = 1, depth = 0, error = 0. Reset mid-word discards the partial word.
- No wrap-around: depth never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: BLOCK_NEST_CASE_KW_EN.
- Defined: adds "case" (opens T_CASE) and "endcase" (closes T_CASE). The FSM extends EN/END through ENDC, ENDCA, ENDCAS, ENDCASE, so "end" and "endcase" share a prefix. "endc" alone is a plain word. Also adds C, CA, CAS, CASE.
- Undefined: "case" and "endcase" are plain words; the stack type field is still 2 bits wide.

Decomposition:
- Package block_nest_pkg:
  - kw_e enum: KW_NONE, KW_BEGIN, KW_END, KW_FORK, KW_JOIN, KW_CASE, KW_ENDCASE.
  - 2-bit type codes T_BEGIN = 0, T_FORK = 1, T_CASE = 2.
  - Constants CH_SPACE = 8'h20 and CASE_FOLD = 8'h20.
  - Function kw_is_open and function kw_type.
- Sub-module kw_matcher: word FSM. Ports clk, reset, ch, kw_o.
- The top level holds the stack, the commit logic and the pending view.

Test Plan:
- Reset, then "BeGiN eNd " → result = 0 one cycle after the 'N' of BeGiN, depth = 1. After the 'd': result = 1, depth = 0. error stays 0 throughout.
- "begin fork join end" (no trailing space) → after the final 'd': result = 1, depth = 0. After "begin fork": depth = 2.
- "begin join " → error = 1 and result = 0 after the 'n' of join (pending mismatch). Both remain after the space. A subsequent "end begin " leaves depth = 1 and error = 1.
- "end" then 'x' then ' ' → after 'd': error = 1, result = 0. After 'x': error = 0, result = 1 (word became "endx"). After the space, the state is unchanged.
- With DEPTH = 2: "begin begin begin " → error = 1 at the third "begin"; depth holds 2. Assert reset mid-stream → result = 1, depth = 0, error = 0 without waiting for a clock edge.
- With BLOCK_NEST_CASE_KW_EN defined: "case end endcase " → error on "end" (mismatch). In a fresh run, "case endcase " → result = 1. "endc " is ignored (no depth change).

Source files
------------

// File: rtl/block_nest_checker_pkg.sv
// Purpose: shared keyword codes, block type codes and helpers for the nesting checker.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package block_nest_pkg;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CASE_FOLD = 8'h20;

    typedef enum logic [2:0] {
        KW_NONE,
        KW_BEGIN,
        KW_END,
        KW_FORK,
        KW_JOIN,
        KW_CASE,
        KW_ENDCASE
    } kw_e;

    // Stack entries are always 2 bits wide, whether or not case keywords exist.
    typedef logic [1:0] blk_type_t;

    localparam blk_type_t T_BEGIN = 2'd0;
    localparam blk_type_t T_FORK  = 2'd1;
    localparam blk_type_t T_CASE  = 2'd2;

    function automatic logic kw_is_open(input kw_e k);
        return (k == KW_BEGIN) || (k == KW_FORK) || (k == KW_CASE);
    endfunction

    // Block type a keyword opens or closes; KW_NONE maps to T_BEGIN but is never used.
    function automatic blk_type_t kw_type(input kw_e k);
        case (k)
            KW_FORK, KW_JOIN:    return T_FORK;
            KW_CASE, KW_ENDCASE: return T_CASE;
            default:             return T_BEGIN;
        endcase
    endfunction

endpackage

// File: rtl/block_nest_checker_kw_matcher.sv
// Purpose: word FSM; reports which full keyword the current unterminated word equals.
// Latency: kw_o reflects every character sampled up to the last clk edge (registered state).
// Backpressure: none; one folded character consumed every cycle.
// Ports: clk, reset (async active-high), ch (case-folded char), kw_o (keyword code or KW_NONE).
// Optional: BLOCK_NEST_CASE_KW_EN adds the case/endcase branches.
module kw_matcher
    import block_nest_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ch,
    output kw_e        kw_o
);

    typedef enum logic [4:0] {
        S_IDLE,
        S_B, S_BE, S_BEG, S_BEGI, S_BEGIN,
        S_E, S_EN, S_END,
        S_F, S_FO, S_FOR, S_FORK,
        S_J, S_JO, S_JOI, S_JOIN,
        S_C, S_CA, S_CAS, S_CASE,
        S_ENDC, S_ENDCA, S_ENDCAS, S_ENDCASE,
        S_SKIP
    } state_e;

    state_e state, state_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Any character that does not extend a keyword prefix (including one
    // after a complete keyword) drops into SKIP until the next space.
    always_comb begin
        state_n = S_SKIP;
        if (ch == CH_SPACE) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ch == "b") state_n = S_B;
                    if (ch == "e") state_n = S_E;
                    if (ch == "f") state_n = S_F;
                    if (ch == "j") state_n = S_J;
`ifdef BLOCK_NEST_CASE_KW_EN
                    if (ch == "c") state_n = S_C;
`endif
                end
                S_B:    if (ch == "e") state_n = S_BE;
                S_BE:   if (ch == "g") state_n = S_BEG;
                S_BEG:  if (ch == "i") state_n = S_BEGI;
                S_BEGI: if (ch == "n") state_n = S_BEGIN;
                S_E:    if (ch == "n") state_n = S_EN;
                S_EN:   if (ch == "d") state_n = S_END;
                S_F:    if (ch == "o") state_n = S_FO;
                S_FO:   if (ch == "r") state_n = S_FOR;
                S_FOR:  if (ch == "k") state_n = S_FORK;
                S_J:    if (ch == "o") state_n = S_JO;
                S_JO:   if (ch == "i") state_n = S_JOI;
                S_JOI:  if (ch == "n") state_n = S_JOIN;
`ifdef BLOCK_NEST_CASE_KW_EN
                // "end" is itself a prefix of "endcase".
                S_END:    if (ch == "c") state_n = S_ENDC;
                S_ENDC:   if (ch == "a") state_n = S_ENDCA;
                S_ENDCA:  if (ch == "s") state_n = S_ENDCAS;
                S_ENDCAS: if (ch == "e") state_n = S_ENDCASE;
                S_C:      if (ch == "a") state_n = S_CA;
                S_CA:     if (ch == "s") state_n = S_CAS;
                S_CAS:    if (ch == "e") state_n = S_CASE;
`endif
                default: state_n = S_SKIP;
            endcase
        end
    end

    always_comb begin
        kw_o = KW_NONE;
        case (state)
            S_BEGIN:   kw_o = KW_BEGIN;
            S_END:     kw_o = KW_END;
            S_FORK:    kw_o = KW_FORK;
            S_JOIN:    kw_o = KW_JOIN;
            S_CASE:    kw_o = KW_CASE;
            S_ENDCASE: kw_o = KW_ENDCASE;
            default:   kw_o = KW_NONE;
        endcase
    end

endmodule

// File: rtl/block_nest_checker.sv
// Purpose: checks nesting of space-delimited open/close keywords in a char stream.
// Latency: outputs reflect all chars up to the last clk edge (1 cycle), pending word included.
// Backpressure: none; one character accepted every cycle.
// Ports: clk, reset (async active-high), in (ASCII char), result (balanced and
//        error-free), depth (effective nesting depth), error (sticky structural error).
// Optional: BLOCK_NEST_CASE_KW_EN enables case/endcase keywords (in kw_matcher).
module block_nest_checker
    import block_nest_pkg::*;
#(
    parameter  int DEPTH   = 16,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               error
);

    logic [7:0] ch;
    kw_e        kw;

    assign ch = in | CASE_FOLD;

    kw_matcher u_kw (
        .clk   (clk),
        .reset (reset),
        .ch    (ch),
        .kw_o  (kw)
    );

    // Shift-register stack: entry 0 is always the top, so no pointer indexing.
    logic [DEPTH_W-1:0] sp;
    logic               err;
    blk_type_t          stk [DEPTH];

    logic is_open, is_close, at_full, at_empty, top_mis, commit, eff_err;

    assign is_open  = kw_is_open(kw);
    assign is_close = (kw != KW_NONE) && !is_open;
    assign at_full  = (sp == DEPTH_W'(DEPTH));
    assign at_empty = (sp == '0);
    assign top_mis  = !at_empty && (stk[0] != kw_type(kw));
    // kw is still the finished word on the edge that samples its terminating space.
    assign commit   = (ch == CH_SPACE) && (kw != KW_NONE) && !err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp  <= '0;
            err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= T_BEGIN;
        end else if (commit) begin
            if (is_open) begin
                if (at_full) begin
                    err <= 1'b1;
                end else begin
                    for (int i = DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
                    stk[0] <= kw_type(kw);
                    sp     <= sp + 1'b1;
                end
            end else if (at_empty || top_mis) begin
                err <= 1'b1;
            end else begin
                for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                stk[DEPTH-1] <= T_BEGIN;
                sp           <= sp - 1'b1;
            end
        end
    end

    // Pending view: treat the current unterminated keyword as already committed.
    assign eff_err = err
                   | (is_open  && at_full)
                   | (is_close && (at_empty || top_mis));

    always_comb begin
        depth = sp;
        if (!eff_err) begin
            if (is_open)  depth = sp + 1'b1;
            if (is_close) depth = sp - 1'b1;
        end
    end

    assign error  = eff_err;
    assign result = !eff_err && (depth == '0);

endmodule
